// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, programmable wait, registered response.
// Optional macro IMEM_STAT_EN adds request/error statistics counters.
//
// state   | meaning
// IDLE    | ready for a fetch request
// WAIT    | counting down the programmed latency
// RESP    | response valid, holding until the IF stage takes it
module imem_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_inst,
  output logic                  rsp_err,
`ifdef IMEM_STAT_EN
  output logic [31:0]           stat_req_cnt,
  output logic [31:0]           stat_err_cnt,
`endif
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0]            WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(4) << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [1<<DEPTH_LOG2];

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  rd_err;
  logic                  accept;
  logic                  enter_resp;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // With zero latency the read happens on the accept edge, before addr_q holds the address.
  assign rd_addr    = (state == ST_IDLE) ? req_addr : addr_q;
  assign offset     = rd_addr - BASE_ADDR;
  assign rd_err     = (rd_addr[1:0] != 2'b00) || (offset >= SPAN);
  assign enter_resp = ((state == ST_IDLE) && accept && (LATENCY == 0)) ||
                      ((state == ST_WAIT) && (cnt == 4'd0));

  // Loader writes are independent of reset so the harness can preload during reset.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_inst  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= rd_err;
        rsp_inst  <= rd_err ? '0 : mem[offset[DEPTH_LOG2+1:2]];
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            if (LATENCY == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IMEM_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_req_cnt <= 32'd0;
      stat_err_cnt <= 32'd0;
    end else begin
      if (accept) stat_req_cnt <= stat_req_cnt + 32'd1;
      if (rsp_valid && rsp_ready && rsp_err) stat_err_cnt <= stat_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance (a) and a LATENCY=0 instance (b).
// Statistics checks are compiled in when IMEM_STAT_EN is defined.
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_rsp_inst;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_rsp_inst;
`ifdef IMEM_STAT_EN
  logic [31:0] a_stat_req, a_stat_err, b_stat_req, b_stat_err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit sel_r = 1'b0;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_inst;
  assign m_req_ready = sel_r ? b_req_ready : a_req_ready;
  assign m_rsp_valid = sel_r ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_err   = sel_r ? b_rsp_err   : a_rsp_err;
  assign m_rsp_inst  = sel_r ? b_rsp_inst  : a_rsp_inst;

  imem_responder #(.LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_inst(a_rsp_inst), .rsp_err(a_rsp_err),
`ifdef IMEM_STAT_EN
    .stat_req_cnt(a_stat_req), .stat_err_cnt(a_stat_err),
`endif
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.LATENCY(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_inst(b_rsp_inst), .rsp_err(b_rsp_err),
`ifdef IMEM_STAT_EN
    .stat_req_cnt(b_stat_req), .stat_err_cnt(b_stat_err),
`endif
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick;
    ld_we = 1'b0;
  endtask

  task automatic set_req(input bit sel, input logic v, input logic [31:0] a);
    if (sel) begin b_req_valid = v; b_req_addr = a; end
    else     begin a_req_valid = v; a_req_addr = a; end
  endtask

  task automatic set_rdy(input bit sel, input logic r);
    if (sel) b_rsp_ready = r;
    else     a_rsp_ready = r;
  endtask

  // hold: cycles the response is back-pressured; exp_inst: word the response must keep showing
  task automatic fetch(input bit sel, input logic [31:0] addr, input int hold,
                       input logic [31:0] exp_inst,
                       output logic [31:0] inst, output logic err,
                       output int lat, output int acc);
    int n;
    sel_r = sel;
    n = 0;
    set_req(sel, 1'b1, addr);
    set_rdy(sel, hold == 0);
    while (!m_req_ready && n < 20) begin tick; n++; end
    if (!m_req_ready) chk("accept_timeout", 0, 1);
    tick;
    acc = cyc;
    set_req(sel, hold > 0, 32'hFFFF_FFF3);
    lat = 0;
    while (!m_rsp_valid && lat < 40) begin tick; lat++; end
    if (!m_rsp_valid) chk("rsp_timeout", 0, 1);
    inst = m_rsp_inst;
    err  = m_rsp_err;
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("bp_valid", m_rsp_valid, 1);
      chk("bp_inst",  m_rsp_inst,  exp_inst);
      chk("bp_ready", m_req_ready, 0);
    end
    set_rdy(sel, 1'b1);
    tick;
    set_req(sel, 1'b0, 32'h0);
    chk("hs_valid", m_rsp_valid, 0);
    chk("hs_ready", m_req_ready, 1);
    chk("hs_keep",  m_rsp_inst,  exp_inst);
  endtask

  logic [31:0] inst;
  logic        err;
  int          lat, acc1, acc2;
  logic        seen;

  initial begin
    rst = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0;
    tick;
    tick;
    // memory is loaded while reset is still asserted
    load(10'd0,    32'h0000_0413);
    load(10'd1,    32'h0010_0093);
    load(10'd2,    32'h1111_1111);
    load(10'd1023, 32'hDEAD_BEEF);
    chk("rst_valid", a_rsp_valid, 0);
    chk("rst_inst",  a_rsp_inst,  0);
    chk("rst_err",   a_rsp_err,   0);
    chk("rst_ready", a_req_ready, 1);
    rst = 1'b1;
    tick;

    fetch(0, 32'h8000_0000, 0, 32'h0000_0413, inst, err, lat, acc1);
    chk("basic_inst", inst, 32'h0000_0413);
    chk("basic_err",  err,  0);
    chk("basic_lat",  lat,  2);

    fetch(0, 32'h8000_0004, 5, 32'h0010_0093, inst, err, lat, acc1);
    chk("bp_first_inst", inst, 32'h0010_0093);
    chk("bp_first_err",  err,  0);

    fetch(0, 32'h8000_0FFC, 0, 32'hDEAD_BEEF, inst, err, lat, acc1);
    chk("top_word_inst", inst, 32'hDEAD_BEEF);
    chk("top_word_err",  err,  0);

    fetch(0, 32'h8000_0002, 0, 32'h0, inst, err, lat, acc1);
    chk("misalign_err",  err,  1);
    chk("misalign_inst", inst, 0);

`ifdef IMEM_STAT_EN
    chk("stat_req", a_stat_req, 4);
    chk("stat_err", a_stat_err, 1);
`endif

    fetch(0, 32'h8000_1000, 0, 32'h0, inst, err, lat, acc1);
    chk("oor_high_err",  err,  1);
    chk("oor_high_inst", inst, 0);
    fetch(0, 32'h7FFF_FFFC, 0, 32'h0, inst, err, lat, acc2);
    chk("oor_low_err",  err,  1);
    chk("spacing_l2",   acc2 - acc1, 4);

    fetch(1, 32'h8000_0000, 0, 32'h0000_0413, inst, err, lat, acc1);
    chk("l0_inst0", inst, 32'h0000_0413);
    chk("l0_lat0",  lat,  0);
    fetch(1, 32'h8000_0004, 0, 32'h0010_0093, inst, err, lat, acc2);
    chk("l0_inst1",    inst, 32'h0010_0093);
    chk("l0_lat1",     lat,  0);
    chk("spacing_l0",  acc2 - acc1, 2);

    // write landing on the RESP-entry edge must not be seen by that read
    sel_r = 1'b1;
    b_req_valid = 1'b1; b_req_addr = 32'h8000_0008; b_rsp_ready = 1'b1;
    ld_we = 1'b1; ld_addr = 10'd2; ld_data = 32'h2222_2222;
    tick;
    ld_we = 1'b0; b_req_valid = 1'b0;
    chk("same_edge_valid", b_rsp_valid, 1);
    chk("same_edge_old",   b_rsp_inst,  32'h1111_1111);
    tick;
    fetch(1, 32'h8000_0008, 0, 32'h2222_2222, inst, err, lat, acc1);
    chk("later_read_new", inst, 32'h2222_2222);

    sel_r = 1'b0;
    a_req_valid = 1'b1; a_req_addr = 32'h8000_0000; a_rsp_ready = 1'b1;
    tick;
    a_req_valid = 1'b0;
    chk("wait_no_valid", a_rsp_valid, 0);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("midrst_ready", a_req_ready, 1);
    chk("midrst_valid", a_rsp_valid, 0);
`ifdef IMEM_STAT_EN
    chk("stat_req_rst", a_stat_req, 0);
    chk("stat_err_rst", a_stat_err, 0);
`endif
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      seen = seen | a_rsp_valid;
    end
    chk("midrst_no_rsp", seen, 0);
    fetch(0, 32'h8000_0004, 0, 32'h0010_0093, inst, err, lat, acc1);
    chk("after_rst_inst", inst, 32'h0010_0093);
    chk("after_rst_lat",  lat,  2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
